writeback_unit: RTL
===================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH_P, default 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH_P, default 5, register address width.
REQ-003 SHALL have parameter DEPTH_P, default 32, number of architectural registers and scoreboard entries.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports i_alu_valid/o_alu_ready  input/output  1  ALU result handshake; i_alu_addr  input  ADDR_WIDTH_P; i_alu_data  input  DATA_WIDTH_P.
REQ-007 SHALL have ports i_mem_valid/o_mem_ready  input/output  1  load result handshake; i_mem_addr  input  ADDR_WIDTH_P; i_mem_data  input  DATA_WIDTH_P.
REQ-008 SHALL have ports i_issue_valid  input  1, i_issue_addr  input  ADDR_WIDTH_P  marks a destination register as pending.
REQ-009 SHALL have ports i_rd_addr_a, i_rd_addr_b  input  ADDR_WIDTH_P  decode-stage source addresses for hazard lookup.
REQ-010 SHALL have ports o_wr_enable  output  1, o_wr_addr  output  ADDR_WIDTH_P, o_wr_data  output  DATA_WIDTH_P  registered write port to the register file.
REQ-011 SHALL have ports o_busy_a, o_busy_b  output  1  source register has an uncommitted pending write.
REQ-012 SHALL have ports o_fwd_valid_a/b  output  1, o_fwd_data_a/b  output  DATA_WIDTH_P  (present only with WB_FORWARD_EN).

Function
REQ-013 SHALL transfer on a source only when valid and ready are both high at a rising edge.
REQ-014 SHALL buffer load results in a 2-entry FIFO; o_mem_ready = FIFO count < 2.
REQ-015 SHALL drive o_alu_ready = FIFO empty and no load being accepted this cycle; loads always have priority.
REQ-016 SHALL, each edge: if FIFO non-empty, pop head into output register; else if ALU transfer, load ALU result into output register; else o_wr_enable <= 0.
REQ-017 SHALL give ALU latency 1 (accepted edge N -> o_wr_enable high cycle N+1) and load latency 2 with empty FIFO.
REQ-018 SHALL allow FIFO push and pop on the same edge; count unchanged, order preserved.
REQ-019 SHALL hold o_wr_enable high exactly one cycle per committed result.
REQ-020 SHALL accept results with address 0 (handshake completes, FIFO consumed) but keep o_wr_enable low for them.
REQ-021 SHALL keep a DEPTH_P-bit busy scoreboard: set busy[i_issue_addr] on i_issue_valid, never for address 0.
REQ-022 SHALL clear busy[o_wr_addr] at the edge on which o_wr_enable is high (register-file commit edge).
REQ-023 SHALL let set win over clear when issue and commit target the same address on the same edge.
REQ-024 SHALL drive o_busy_a = busy[i_rd_addr_a] combinationally (same for b); address 0 always 0.

Reset
REQ-025 SHALL, with reset high at an edge: o_wr_enable=0, o_wr_addr=0, o_wr_data=0, FIFO count=0, all busy bits 0; in-flight results discarded.
REQ-026 SHALL drive o_alu_ready=0 and o_mem_ready=0 while reset is high.
REQ-027 SHALL ignore i_issue_valid and all valid inputs while reset is high.

Configuration
REQ-028 SHALL compile forwarding in only when macro WB_FORWARD_EN is defined.
REQ-029 SHALL, with WB_FORWARD_EN: o_fwd_valid_a = o_wr_enable and o_wr_addr==i_rd_addr_a and addr!=0, o_fwd_data_a = o_wr_data (same for b); o_busy_a forced 0 when o_fwd_valid_a high.
REQ-030 SHALL, without WB_FORWARD_EN: omit fwd ports; o_busy stays high through the commit cycle as per REQ-024.

Verification
REQ-031 SHALL cover: ALU valid addr=5 data=0xDEADBEEF at edge N -> o_wr_enable=1, addr=5, data=0xDEADBEEF in cycle N+1 only.
REQ-032 SHALL cover: ALU and mem valid same cycle (addr 3 / addr 7) -> mem accepted, o_alu_ready=0; addr 7 written first, ALU accepted once FIFO empty, addr 3 written after.
REQ-033 SHALL cover: three back-to-back loads with ALU idle -> o_mem_ready never drops, writes in order, one per cycle.
REQ-034 SHALL cover: issue addr=9, rd_addr_a=9 -> o_busy_a=1 until commit; commit cycle busy=1 (fwd_valid_a=1, busy=0 with WB_FORWARD_EN); next cycle 0.
REQ-035 SHALL cover: ALU result addr=0 data=0x1234 -> o_alu_ready handshake completes, o_wr_enable stays 0.
REQ-036 SHALL cover: reset asserted with 2 loads in FIFO and busy[4]=1 -> next cycle o_wr_enable=0, FIFO empty, o_busy for 4 = 0.

Source files
------------

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - writeback arbiter with load FIFO, register-file write port and busy scoreboard
//
// Purpose:
//   Merges ALU results and load results into one registered register-file
//   write port. Loads always win and are staged through a 2-entry FIFO.
//   A busy scoreboard marks destination registers with pending writes so
//   that decode can detect hazards.
//
// Optional feature:
//   WB_FORWARD_EN - when defined, adds forwarding of the write port value
//   to the two decode source addresses.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   i_alu_valid/o_alu_ready             ALU result handshake; i_alu_addr, i_alu_data
//   i_mem_valid/o_mem_ready             load result handshake; i_mem_addr, i_mem_data
//   i_issue_valid, i_issue_addr         marks a destination register pending
//   i_rd_addr_a, i_rd_addr_b            decode source addresses
//   o_wr_enable, o_wr_addr, o_wr_data   registered register-file write port
//   o_busy_a, o_busy_b                  source has an uncommitted pending write
//   o_fwd_valid_a/b, o_fwd_data_a/b     forwarding (WB_FORWARD_EN only)

module writeback_unit #(
  parameter int DATA_WIDTH_P = 32,
  parameter int ADDR_WIDTH_P = 5,
  parameter int DEPTH_P      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_alu_valid,
  output logic                    o_alu_ready,
  input  logic [ADDR_WIDTH_P-1:0] i_alu_addr,
  input  logic [DATA_WIDTH_P-1:0] i_alu_data,
  input  logic                    i_mem_valid,
  output logic                    o_mem_ready,
  input  logic [ADDR_WIDTH_P-1:0] i_mem_addr,
  input  logic [DATA_WIDTH_P-1:0] i_mem_data,
  input  logic                    i_issue_valid,
  input  logic [ADDR_WIDTH_P-1:0] i_issue_addr,
  input  logic [ADDR_WIDTH_P-1:0] i_rd_addr_a,
  input  logic [ADDR_WIDTH_P-1:0] i_rd_addr_b,
  output logic                    o_wr_enable,
  output logic [ADDR_WIDTH_P-1:0] o_wr_addr,
  output logic [DATA_WIDTH_P-1:0] o_wr_data,
  output logic                    o_busy_a,
  output logic                    o_busy_b
`ifdef WB_FORWARD_EN
  ,
  output logic                    o_fwd_valid_a,
  output logic                    o_fwd_valid_b,
  output logic [DATA_WIDTH_P-1:0] o_fwd_data_a,
  output logic [DATA_WIDTH_P-1:0] o_fwd_data_b
`endif
);

  // Load FIFO storage: two slots addressed by a 1-bit read pointer.
  logic [ADDR_WIDTH_P-1:0] r_fifo_addr [2];
  logic [DATA_WIDTH_P-1:0] r_fifo_data [2];
  logic                    r_rd_ptr;
  logic [1:0]              r_count;

  logic [DEPTH_P-1:0]      r_busy;

  logic                    w_mem_fire;
  logic                    w_alu_fire;
  logic                    w_pop;
  logic                    w_wr_ptr;
  logic [ADDR_WIDTH_P-1:0] w_head_addr;
  logic [DATA_WIDTH_P-1:0] w_head_data;
  logic                    w_busy_a;
  logic                    w_busy_b;

  assign o_mem_ready = !reset && (r_count != 2'd2);
  assign w_mem_fire  = i_mem_valid && o_mem_ready;
  // ALU is only let in when no load is waiting or arriving, so loads never stall.
  assign o_alu_ready = !reset && (r_count == 2'd0) && !w_mem_fire;
  assign w_alu_fire  = i_alu_valid && o_alu_ready;

  assign w_pop       = (r_count != 2'd0);
  // Write slot is the one after the occupied ones (count is 0 or 1 when pushing).
  assign w_wr_ptr    = r_rd_ptr ^ r_count[0];
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  // FIFO payload needs no reset: r_count gates every read.
  always_ff @(posedge clk) begin
    if (w_mem_fire) begin
      r_fifo_addr[w_wr_ptr] <= i_mem_addr;
      r_fifo_data[w_wr_ptr] <= i_mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= 2'd0;
      r_rd_ptr    <= 1'b0;
      o_wr_enable <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_mem_fire, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      // Address 0 results are consumed but never written.
      if (w_pop) begin
        o_wr_enable <= (w_head_addr != '0);
        o_wr_addr   <= w_head_addr;
        o_wr_data   <= w_head_data;
      end else if (w_alu_fire) begin
        o_wr_enable <= (i_alu_addr != '0);
        o_wr_addr   <= i_alu_addr;
        o_wr_data   <= i_alu_data;
      end else begin
        o_wr_enable <= 1'b0;
      end
    end
  end

  // Set is written last so it wins over a same-edge commit clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (o_wr_enable) begin
        r_busy[o_wr_addr] <= 1'b0;
      end
      if (i_issue_valid && (i_issue_addr != '0)) begin
        r_busy[i_issue_addr] <= 1'b1;
      end
    end
  end

  assign w_busy_a = (i_rd_addr_a != '0) && r_busy[i_rd_addr_a];
  assign w_busy_b = (i_rd_addr_b != '0) && r_busy[i_rd_addr_b];

`ifdef WB_FORWARD_EN
  assign o_fwd_valid_a = o_wr_enable && (o_wr_addr == i_rd_addr_a) && (i_rd_addr_a != '0);
  assign o_fwd_valid_b = o_wr_enable && (o_wr_addr == i_rd_addr_b) && (i_rd_addr_b != '0);
  assign o_fwd_data_a  = o_wr_data;
  assign o_fwd_data_b  = o_wr_data;
  // A forwarded value resolves the hazard in the commit cycle itself.
  assign o_busy_a      = w_busy_a && !o_fwd_valid_a;
  assign o_busy_b      = w_busy_b && !o_fwd_valid_b;
`else
  assign o_busy_a      = w_busy_a;
  assign o_busy_b      = w_busy_b;
`endif

endmodule
